axif_burst_mem_slave: RTL

AXI4-Full slave backed by a word-addressed on-chip memory. It is the downstream consumer of the M_AXIF burst master, which writes a burst and then reads it back for comparison. It handles one transaction at a time, supports INCR and FIXED bursts up to 256 beats, and reports a per-transaction error response.

---
 rtl/axif_burst_mem_slave.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axif_burst_mem_slave.sv
// AXI4-Full slave over a word-addressed synchronous RAM; one transaction
// at a time, INCR/FIXED bursts up to 256 beats, SLVERR on bad bursts.
module axif_burst_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH_WORDS    = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int MEM_AW = $clog2(MEM_DEPTH_WORDS);
    // Extra headroom so a burst running past the top can be detected
    localparam int IDX_W  = AW + 7;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(MEM_DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_t;

    state_t state_q, state_d;

    logic [C_S_AXI_ID_WIDTH-1:0] id_q;
    logic [IDX_W-1:0]            idx_q;
    logic [7:0]                  len_q;
    logic [7:0]                  beat_q;
    logic                        fixed_q;
    logic                        err_q;

    logic                        rvalid_q;
    logic                        rlast_q;
    logic [1:0]                  rresp_q;
    logic [DW-1:0]               rdata_q;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_q;

    logic [DW-1:0] mem [MEM_DEPTH_WORDS];

    logic aw_hs;
    logic ar_hs;
    logic w_hs;
    logic fetch;
    logic r_done;
    logic in_range;
    logic [IDX_W-1:0] idx_next;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs    = (state_q == IDLE) && S_AXI_AWVALID;
    assign ar_hs    = (state_q == IDLE) && !S_AXI_AWVALID && S_AXI_ARVALID;
    assign w_hs     = (state_q == WDATA) && S_AXI_WVALID;
    // Read port runs whenever the output beat is empty or being consumed
    assign fetch    = (state_q == RDATA) &&
                      (!rvalid_q || (S_AXI_RREADY && !rlast_q));
    assign r_done   = (state_q == RDATA) && rvalid_q &&
                      S_AXI_RREADY && rlast_q;
    assign in_range = idx_q < DEPTH;
    assign idx_next = fixed_q ? idx_q : idx_q + IDX_W'(1);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        S_AXI_BID     = '0;
        unique case (state_q)
            IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_ARREADY = !S_AXI_AWVALID;
                if (S_AXI_AWVALID) begin
                    state_d = WDATA;
                end else if (S_AXI_ARVALID) begin
                    state_d = RDATA;
                end
            end
            WDATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && S_AXI_WLAST) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                S_AXI_BID    = id_q;
                if (S_AXI_BREADY) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (r_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q     <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            fixed_q  <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            if (aw_hs) begin
                id_q    <= S_AXI_AWID;
                idx_q   <= IDX_W'(S_AXI_AWADDR[AW-1:2]);
                len_q   <= S_AXI_AWLEN;
                beat_q  <= '0;
                fixed_q <= (S_AXI_AWBURST == 2'b00);
                err_q   <= (S_AXI_AWSIZE != 3'd2) || S_AXI_AWBURST[1];
            end else if (ar_hs) begin
                id_q    <= S_AXI_ARID;
                idx_q   <= IDX_W'(S_AXI_ARADDR[AW-1:2]);
                len_q   <= S_AXI_ARLEN;
                beat_q  <= '0;
                fixed_q <= (S_AXI_ARBURST == 2'b00);
                err_q   <= (S_AXI_ARSIZE != 3'd2) || S_AXI_ARBURST[1];
            end

            if (w_hs) begin
                beat_q <= beat_q + 8'd1;
                idx_q  <= idx_next;
                // WLAST early or late, or a dropped beat, poisons BRESP
                if (!in_range || (S_AXI_WLAST != (beat_q == len_q))) begin
                    err_q <= 1'b1;
                end
            end

            if (fetch) begin
                rvalid_q <= 1'b1;
                rdata_q  <= in_range ? mem[idx_q[MEM_AW-1:0]] : '0;
                rresp_q  <= (!in_range || err_q) ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= (beat_q == len_q);
                rid_q    <= id_q;
                beat_q   <= beat_q + 8'd1;
                idx_q    <= idx_next;
            end else if (r_done) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && in_range) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[idx_q[MEM_AW-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RLAST  = rlast_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RID    = rid_q;

endmodule
